// File: rtl/eco32f_ram_pkg.sv
// Shared helpers for the eco32f RAM family: lane count, width legality check
// and the byte-lane merge used by the read-during-write bypass.
package eco32f_ram_pkg;

  localparam int MAX_DW = 1024;

  function automatic int nb(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  function automatic bit width_ok(input int data_width, input int byte_width);
    return (byte_width > 32'sd0) && (data_width % byte_width == 32'sd0) &&
           (data_width <= MAX_DW);
  endfunction

  // Bitwise select: mask bit set takes the new data, clear keeps the old.
  function automatic logic [MAX_DW-1:0] merge(input logic [MAX_DW-1:0] old_w,
                                               input logic [MAX_DW-1:0] new_w,
                                               input logic [MAX_DW-1:0] mask_w);
    return (old_w & ~mask_w) | (new_w & mask_w);
  endfunction

endpackage

// File: rtl/eco32f_dpram_be_sclk.sv
// Single-clock simple dual-port RAM with byte-lane write enables, per-byte
// read-during-write bypass, optional output register and a read-valid strobe.
module eco32f_dpram_be_sclk
  import eco32f_ram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int ENABLE_BYPASS = 1,
  parameter int OUTPUT_REG    = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ADDR_WIDTH-1:0]                  raddr,
  input  logic                                   re,
  input  logic [ADDR_WIDTH-1:0]                  waddr,
  input  logic                                   we,
  input  logic [nb(DATA_WIDTH, BYTE_WIDTH)-1:0]  be,
  input  logic [DATA_WIDTH-1:0]                  din,
  output logic [DATA_WIDTH-1:0]                  dout,
  output logic                                   dout_valid
);

  localparam int NB    = nb(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (!width_ok(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_width
    $error("eco32f_dpram_be_sclk: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] be_bits_s;
  logic [DATA_WIDTH-1:0] stage1_s;
  logic                  byp_hit_s;

  logic [DATA_WIDTH-1:0] rd_d, rd_q;
  logic [DATA_WIDTH-1:0] byp_data_d, byp_data_q;
  logic [DATA_WIDTH-1:0] byp_mask_d, byp_mask_q;
  logic                  v1_d, v1_q;

  // One narrow array per lane so tools map it onto byte-enabled block RAM.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [BYTE_WIDTH-1:0] mem_lane [DEPTH];

    always_ff @(posedge clk) begin
      if (we && be[i]) begin
        mem_lane[waddr] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end

    assign rd_word_s[i*BYTE_WIDTH +: BYTE_WIDTH] = mem_lane[raddr];
    assign be_bits_s[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{be[i]}};
  end

  if (ENABLE_BYPASS != 0) begin : g_bypass
    assign byp_hit_s = we & (raddr == waddr);
  end else begin : g_no_bypass
    assign byp_hit_s = 1'b0;
  end

  // Stage 1 only loads on a read, so dout holds between reads; the array
  // read returns the pre-write word and the mask overlays the new bytes.
  always_comb begin
    rd_d       = rd_q;
    byp_data_d = byp_data_q;
    byp_mask_d = byp_mask_q;
    v1_d       = re;
    if (re) begin
      rd_d       = rd_word_s;
      byp_data_d = din;
      byp_mask_d = byp_hit_s ? be_bits_s : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q       <= '0;
      byp_data_q <= '0;
      byp_mask_q <= '0;
      v1_q       <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      byp_data_q <= byp_data_d;
      byp_mask_q <= byp_mask_d;
      v1_q       <= v1_d;
    end
  end

  assign stage1_s = DATA_WIDTH'(merge(MAX_DW'(rd_q), MAX_DW'(byp_data_q), MAX_DW'(byp_mask_q)));

  if (OUTPUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] dout_d, dout_q;
    logic                  v2_d, v2_q;

    always_comb begin
      dout_d = v1_q ? stage1_s : dout_q;
      v2_d   = v1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
        v2_q   <= 1'b0;
      end else begin
        dout_q <= dout_d;
        v2_q   <= v2_d;
      end
    end

    assign dout       = dout_q;
    assign dout_valid = v2_q;
  end else begin : g_direct
    assign dout       = stage1_s;
    assign dout_valid = v1_q;
  end

endmodule
